// File: rtl/coram_memory_channel.sv
// CoRAM memory/channel endpoint: a true dual-port RAM shared between user
// logic and its control thread, plus a bidirectional channel made of two
// independent first-word-fall-through FIFOs (up: user->thread, down:
// thread->user).

// Single-clock FWFT FIFO with registered head, full and empty flags.
module coram_fifo #(
  parameter int ADDR_LEN = 4,
  parameter int DATA_W   = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] d,
  input  logic              enq,
  output logic              full,
  output logic [DATA_W-1:0] q,
  input  logic              deq,
  output logic              empty
);
  localparam int DEPTH = 1 << ADDR_LEN;

  logic [DATA_W-1:0]   store [DEPTH];
  logic [ADDR_LEN-1:0] wr_ptr, rd_ptr, rd_next;
  logic [ADDR_LEN:0]   count, count_next;
  logic                do_enq, do_deq;

  // Enqueue at full is dropped even if a dequeue happens in the same cycle.
  assign do_enq     = enq & ~full;
  assign do_deq     = deq & ~empty;
  assign count_next = count + (ADDR_LEN+1)'(do_enq) - (ADDR_LEN+1)'(do_deq);
  assign rd_next    = rd_ptr + ADDR_LEN'(do_deq);

  // Entry storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_enq) store[wr_ptr] <= d;
  end

  // Pointers, occupancy, flags and the registered head word.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      q      <= '0;
    end else begin
      wr_ptr <= wr_ptr + ADDR_LEN'(do_enq);
      rd_ptr <= rd_next;
      count  <= count_next;
      full   <= (count_next == (ADDR_LEN+1)'(DEPTH));
      empty  <= (count_next == '0);
      // Head comes straight from the input when the word being written is
      // the only one left; otherwise from storage. Hold when going empty.
      if (count_next != '0) begin
        if (do_enq && (rd_next == wr_ptr)) q <= d;
        else                               q <= store[rd_next];
      end
    end
  end
endmodule

module coram_memory_channel #(
  parameter string THREAD_NAME  = "ctrl_thread",
  parameter int    MEM_ID       = 0,
  parameter int    MEM_ADDR_LEN = 7,
  parameter int    MEM_DATA_W   = 32,
  parameter int    CH_ID        = 0,
  parameter int    CH_ADDR_LEN  = 4,
  parameter int    CH_DATA_W    = 64
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [MEM_ADDR_LEN-1:0] MEM_ADDR,
  input  logic [MEM_DATA_W-1:0]   MEM_D,
  input  logic                    MEM_WE,
  output logic [MEM_DATA_W-1:0]   MEM_Q,
  input  logic [MEM_ADDR_LEN-1:0] T_MEM_ADDR,
  input  logic [MEM_DATA_W-1:0]   T_MEM_D,
  input  logic                    T_MEM_WE,
  output logic [MEM_DATA_W-1:0]   T_MEM_Q,
  input  logic [CH_DATA_W-1:0]    CH_D,
  input  logic                    CH_ENQ,
  output logic                    CH_FULL,
  output logic [CH_DATA_W-1:0]    CH_Q,
  input  logic                    CH_DEQ,
  output logic                    CH_EMPTY,
  input  logic [CH_DATA_W-1:0]    T_CH_D,
  input  logic                    T_CH_ENQ,
  output logic                    T_CH_FULL,
  output logic [CH_DATA_W-1:0]    T_CH_Q,
  input  logic                    T_CH_DEQ,
  output logic                    T_CH_EMPTY
);
  localparam int MEM_DEPTH = 1 << MEM_ADDR_LEN;

  logic [MEM_DATA_W-1:0] ram [MEM_DEPTH];

  // RAM writes; the user write is issued last so it wins a same-address
  // collision with the thread port.
  always_ff @(posedge CLK) begin
    if (T_MEM_WE) ram[T_MEM_ADDR] <= T_MEM_D;
    if (MEM_WE)   ram[MEM_ADDR]   <= MEM_D;
  end

  // Registered read-first reads on both ports; reset clears only the outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      MEM_Q   <= '0;
      T_MEM_Q <= '0;
    end else begin
      MEM_Q   <= ram[MEM_ADDR];
      T_MEM_Q <= ram[T_MEM_ADDR];
    end
  end

  coram_fifo #(.ADDR_LEN(CH_ADDR_LEN), .DATA_W(CH_DATA_W)) up_fifo (
    .clk   (CLK),
    .rst   (RST),
    .d     (CH_D),
    .enq   (CH_ENQ),
    .full  (CH_FULL),
    .q     (T_CH_Q),
    .deq   (T_CH_DEQ),
    .empty (T_CH_EMPTY)
  );

  coram_fifo #(.ADDR_LEN(CH_ADDR_LEN), .DATA_W(CH_DATA_W)) down_fifo (
    .clk   (CLK),
    .rst   (RST),
    .d     (T_CH_D),
    .enq   (T_CH_ENQ),
    .full  (T_CH_FULL),
    .q     (CH_Q),
    .deq   (CH_DEQ),
    .empty (CH_EMPTY)
  );
endmodule

// File: tb/tb_coram_memory_channel.sv
// Directed self-checking bench for coram_memory_channel.
module tb_coram_memory_channel;
  logic        CLK = 1'b0;
  logic        RST;
  logic [6:0]  MEM_ADDR, T_MEM_ADDR;
  logic [31:0] MEM_D, T_MEM_D, MEM_Q, T_MEM_Q;
  logic        MEM_WE, T_MEM_WE;
  logic [63:0] CH_D, CH_Q, T_CH_D, T_CH_Q;
  logic        CH_ENQ, CH_FULL, CH_DEQ, CH_EMPTY;
  logic        T_CH_ENQ, T_CH_FULL, T_CH_DEQ, T_CH_EMPTY;

  int n_checks = 0;
  int n_fail   = 0;

  coram_memory_channel dut (
    .CLK(CLK), .RST(RST),
    .MEM_ADDR(MEM_ADDR), .MEM_D(MEM_D), .MEM_WE(MEM_WE), .MEM_Q(MEM_Q),
    .T_MEM_ADDR(T_MEM_ADDR), .T_MEM_D(T_MEM_D), .T_MEM_WE(T_MEM_WE), .T_MEM_Q(T_MEM_Q),
    .CH_D(CH_D), .CH_ENQ(CH_ENQ), .CH_FULL(CH_FULL), .CH_Q(CH_Q),
    .CH_DEQ(CH_DEQ), .CH_EMPTY(CH_EMPTY),
    .T_CH_D(T_CH_D), .T_CH_ENQ(T_CH_ENQ), .T_CH_FULL(T_CH_FULL), .T_CH_Q(T_CH_Q),
    .T_CH_DEQ(T_CH_DEQ), .T_CH_EMPTY(T_CH_EMPTY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [6:0]  addr;
    logic [31:0] exp_q;
  } rd_vec_t;

  rd_vec_t rd_vecs [6];

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    rd_vecs[0] = '{7'd0,   32'd0};
    rd_vecs[1] = '{7'd1,   32'd5};
    rd_vecs[2] = '{7'd127, 32'd635};
    rd_vecs[3] = '{7'd64,  32'd320};
    rd_vecs[4] = '{7'd3,   32'd15};
    rd_vecs[5] = '{7'd100, 32'd500};

    RST = 1'b1;
    MEM_ADDR = '0; MEM_D = '0; MEM_WE = 1'b0;
    T_MEM_ADDR = '0; T_MEM_D = '0; T_MEM_WE = 1'b0;
    CH_D = '0; CH_ENQ = 1'b0; CH_DEQ = 1'b0;
    T_CH_D = '0; T_CH_ENQ = 1'b0; T_CH_DEQ = 1'b0;
    step(); step();
    RST = 1'b0;

    chk("rst_ch_empty",   CH_EMPTY,   1);
    chk("rst_t_ch_empty", T_CH_EMPTY, 1);
    chk("rst_ch_full",    CH_FULL,    0);
    chk("rst_t_ch_full",  T_CH_FULL,  0);
    chk("rst_ch_q",       CH_Q,       0);
    chk("rst_t_ch_q",     T_CH_Q,     0);
    chk("rst_mem_q",      MEM_Q,      0);
    chk("rst_t_mem_q",    T_MEM_Q,    0);

    // Fill memory with 5*k from the user port
    MEM_WE = 1'b1;
    for (int k = 0; k < 128; k++) begin
      MEM_ADDR = 7'(k);
      MEM_D    = 32'(5 * k);
      step();
    end
    MEM_WE = 1'b0;

    // Table-driven reads on both ports, one cycle latency
    for (int i = 0; i < 6; i++) begin
      MEM_ADDR   = rd_vecs[i].addr;
      T_MEM_ADDR = rd_vecs[i].addr;
      step();
      chk($sformatf("mem_rd_%0d", rd_vecs[i].addr),   MEM_Q,   rd_vecs[i].exp_q);
      chk($sformatf("t_mem_rd_%0d", rd_vecs[i].addr), T_MEM_Q, rd_vecs[i].exp_q);
    end

    // Collision at addr 3: both ports read old word, user data stored
    MEM_ADDR = 7'd3;   MEM_D = 32'd99; MEM_WE = 1'b1;
    T_MEM_ADDR = 7'd3; T_MEM_D = 32'd7; T_MEM_WE = 1'b1;
    step();
    MEM_WE = 1'b0; T_MEM_WE = 1'b0;
    chk("coll_mem_q_old",   MEM_Q,   15);
    chk("coll_t_mem_q_old", T_MEM_Q, 15);
    step();
    chk("coll_mem_q_new",   MEM_Q,   99);
    chk("coll_t_mem_q_new", T_MEM_Q, 99);

    // Cross-port: thread writes addr 10 while user reads it
    MEM_ADDR = 7'd10; T_MEM_ADDR = 7'd10; T_MEM_D = 32'd1234; T_MEM_WE = 1'b1;
    step();
    T_MEM_WE = 1'b0;
    chk("xport_old", MEM_Q, 50);
    step();
    chk("xport_new", MEM_Q, 1234);

    // Up FIFO: 17 enqueues, 17th dropped
    CH_ENQ = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      CH_D = 64'(i);
      step();
      if (i == 1)  begin chk("up_nonempty", T_CH_EMPTY, 0); chk("up_fwft_head", T_CH_Q, 1); end
      if (i == 15) chk("up_full_at15", CH_FULL, 0);
      if (i == 16) chk("up_full_at16", CH_FULL, 1);
    end
    CH_ENQ = 1'b0;
    chk("up_full_after17", CH_FULL, 1);
    for (int i = 1; i <= 16; i++) begin
      chk($sformatf("up_pop_%0d", i), T_CH_Q, 64'(i));
      T_CH_DEQ = 1'b1;
      step();
    end
    T_CH_DEQ = 1'b0;
    chk("up_empty_after_drain", T_CH_EMPTY, 1);
    chk("up_q_hold", T_CH_Q, 16);
    chk("up_not_full", CH_FULL, 0);

    // Dequeue while empty is ignored
    T_CH_DEQ = 1'b1; step(); T_CH_DEQ = 1'b0;
    chk("up_deq_empty_ignored", T_CH_EMPTY, 1);

    // Down FIFO FWFT
    T_CH_D = 64'h64; T_CH_ENQ = 1'b1;
    step();
    T_CH_ENQ = 1'b0;
    chk("dn_fwft_empty", CH_EMPTY, 0);
    chk("dn_fwft_q",     CH_Q,     64'h64);
    step();
    chk("dn_fwft_q_stable", CH_Q, 64'h64);
    CH_DEQ = 1'b1; step(); CH_DEQ = 1'b0;
    chk("dn_empty_after_pop", CH_EMPTY, 1);

    // Simultaneous enq+deq with one word queued
    T_CH_D = 64'h5; T_CH_ENQ = 1'b1; step();
    T_CH_D = 64'hA; CH_DEQ = 1'b1; step();
    T_CH_ENQ = 1'b0; CH_DEQ = 1'b0;
    chk("sim1_empty", CH_EMPTY, 0);
    chk("sim1_head",  CH_Q,     64'hA);
    CH_DEQ = 1'b1; step(); CH_DEQ = 1'b0;
    chk("sim1_count_one", CH_EMPTY, 1);

    // Simultaneous enq+deq at full: new word dropped, count 15
    T_CH_ENQ = 1'b1;
    for (int i = 0; i < 16; i++) begin
      T_CH_D = 64'h100 + 64'(i);
      step();
    end
    chk("dn_full", T_CH_FULL, 1);
    T_CH_D = 64'hDEAD; CH_DEQ = 1'b1;
    step();
    T_CH_ENQ = 1'b0; CH_DEQ = 1'b0;
    chk("simf_not_full", T_CH_FULL, 0);
    for (int i = 1; i < 16; i++) begin
      chk($sformatf("simf_pop_%0d", i), CH_Q, 64'h100 + 64'(i));
      CH_DEQ = 1'b1;
      step();
    end
    CH_DEQ = 1'b0;
    chk("simf_drained", CH_EMPTY, 1);
    chk("simf_q_hold", CH_Q, 64'h10F);

    // Reset with 5 words in each FIFO
    CH_ENQ = 1'b1; T_CH_ENQ = 1'b1;
    for (int i = 0; i < 5; i++) begin
      CH_D = 64'h200 + 64'(i); T_CH_D = 64'h300 + 64'(i);
      step();
    end
    CH_ENQ = 1'b0; T_CH_ENQ = 1'b0;
    chk("pre_rst_up",   T_CH_EMPTY, 0);
    chk("pre_rst_down", CH_EMPTY,   0);
    RST = 1'b1; step(); RST = 1'b0;
    chk("post_rst_ch_empty",   CH_EMPTY,   1);
    chk("post_rst_t_ch_empty", T_CH_EMPTY, 1);
    chk("post_rst_ch_full",    CH_FULL,    0);
    chk("post_rst_t_ch_full",  T_CH_FULL,  0);
    chk("post_rst_ch_q",       CH_Q,       0);
    chk("post_rst_t_ch_q",     T_CH_Q,     0);
    MEM_ADDR = 7'd3; T_MEM_ADDR = 7'd3;
    step();
    chk("post_rst_ram3",   MEM_Q,   99);
    chk("post_rst_t_ram3", T_MEM_Q, 99);
    step();
    chk("post_rst_stays_empty", T_CH_EMPTY, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
